div_basic: RTL and testbench

- Sequential signed integer divider using restoring shift-subtract, one quotient bit per clock.
- Sits beside the shift-add multiplier in the multiplier/arith DSP area and is its inverse operation.
- Converts operands to sign-magnitude, iterates M cycles on magnitudes, then restores signs.
- Quotient truncates toward zero; remainder takes the dividend's sign.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_abs.sv | 19 +
 rtl/div_basic.sv | 135 +++++++++++++
 tb/tb_div_basic.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
// Holds the control FSM encoding and the iteration-counter width helper.
// No ports; imported by div_basic and div_abs.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_abs.sv
// Two's-complement conditional negate: y = neg ? -a : a (combinational).
// Feeding neg_i with the operand's own sign bit gives its magnitude;
// feeding it with a result sign restores a signed value.
// Ports: a_i (W bits in), neg_i (negate select), y_o (W bits out).
module div_abs
  import div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  // The magnitude of the most-negative value wraps back to itself, which
  // is exactly 2**(W-1) when the result is read as unsigned.
  assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/div_basic.sv
// Sequential signed divider, restoring shift-subtract, one quotient bit per clock.
// Quotient truncates toward zero, remainder takes the dividend's sign; results
// arrive M+1 clocks after the start edge with a one-cycle div_out_valid pulse.
// Ports: clk, rst (async high), div_enable, div_in_a[M], div_in_b[N] in;
//        div_quot[M], div_rem[N], div_out_valid, div_by_zero, busy out.
module div_basic
  import div_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         div_enable,
  input  logic [M-1:0] div_in_a,
  input  logic [N-1:0] div_in_b,
  output logic [M-1:0] div_quot,
  output logic [N-1:0] div_rem,
  output logic         div_out_valid,
  output logic         div_by_zero,
  output logic         busy
);

  localparam int CW = clog2(M + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   q_q, q_d;        // dividend magnitude shifting out, quotient shifting in
  logic [N-1:0]   r_q, r_d;        // partial remainder, always < |b| so N bits suffice
  logic [N-1:0]   babs_q, babs_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic           zero_q, zero_d;
  logic [M-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           vld_q, vld_d;
  logic           dbz_q, dbz_d;

  logic [M-1:0]   a_abs, quot_res;
  logic [N-1:0]   b_abs, rem_res;
  logic [N:0]     r_shift, r_sub;
  logic           ge;

  div_abs #(.W(M)) u_abs_a    (.a_i(div_in_a), .neg_i(div_in_a[M-1]), .y_o(a_abs));
  div_abs #(.W(N)) u_abs_b    (.a_i(div_in_b), .neg_i(div_in_b[N-1]), .y_o(b_abs));
  div_abs #(.W(M)) u_sgn_quot (.a_i(q_q),      .neg_i(sa_q ^ sb_q),   .y_o(quot_res));
  div_abs #(.W(N)) u_sgn_rem  (.a_i(r_q),      .neg_i(sa_q),          .y_o(rem_res));

  assign r_shift = {r_q, q_q[M-1]};
  assign r_sub   = r_shift - {1'b0, babs_q};
  // With a nonzero divisor r_shift < 2*|b| <= 2**N, so the top bit of the
  // difference is a clean borrow: clear means r_shift >= |b|. With a zero
  // divisor the iteration result is discarded in DONE.
  assign ge      = ~r_sub[N];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    babs_d  = babs_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    vld_d   = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (div_enable) begin
          state_d = CALC;
          sa_d    = div_in_a[M-1];
          sb_d    = div_in_b[N-1];
          q_d     = a_abs;
          babs_d  = b_abs;
          zero_d  = (div_in_b == '0);
          cnt_d   = '0;
          r_d     = '0;
        end
      end
      CALC: begin
        q_d   = {q_q[M-2:0], ge};
        r_d   = ge ? r_sub[N-1:0] : r_shift[N-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(M - 1)) state_d = DONE;
      end
      DONE: begin
        quot_d  = zero_q ? '1 : quot_res;
        rem_d   = zero_q ? '0 : rem_res;
        dbz_d   = zero_q;
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      babs_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      babs_q  <= babs_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      dbz_q   <= dbz_d;
    end
  end

  assign div_quot      = quot_q;
  assign div_rem       = rem_q;
  assign div_out_valid = vld_q;
  assign div_by_zero   = dbz_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_div_basic.sv
module tb_div_basic;

  localparam int M = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         div_enable = 1'b0;
  logic [M-1:0] div_in_a = '0;
  logic [N-1:0] div_in_b = '0;
  logic [M-1:0] div_quot;
  logic [N-1:0] div_rem;
  logic         div_out_valid;
  logic         div_by_zero;
  logic         busy;

  div_basic #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .div_enable(div_enable),
    .div_in_a(div_in_a), .div_in_b(div_in_b),
    .div_quot(div_quot), .div_rem(div_rem),
    .div_out_valid(div_out_valid), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           start;
  } exp_t;

  typedef struct {
    logic [M-1:0] a;
    logic [N-1:0] b;
    logic [M-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } vec_t;

  exp_t sb[$];
  exp_t me;
  int   cyc = 0;
  int   chk = 0;
  int   pass_cnt = 0;
  logic prev_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on every valid pulse.
  always @(negedge clk) begin
    if (div_out_valid) begin
      check("valid_single_cycle", {31'd0, prev_vld}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_valid", sb.size(), 32'd1);
      end else begin
        me = sb.pop_front();
        check("quot", {24'd0, div_quot}, {24'd0, me.q});
        check("rem", {28'd0, div_rem}, {28'd0, me.r});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, me.z});
        check("latency", cyc - me.start, M + 1);
        check("busy_low_at_valid", {31'd0, busy}, 32'd0);
      end
    end
    prev_vld = div_out_valid;
  end

  // Called just after a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input vec_t v);
    exp_t e;
    div_in_a   = v.a;
    div_in_b   = v.b;
    div_enable = 1'b1;
    @(negedge clk);
    div_enable = 1'b0;
    e.q = v.q; e.r = v.r; e.z = v.z; e.start = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int exp_busy);
    int n;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, exp_busy);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{a: 8'd100, b: 4'd7,  q: 8'd14,  r: 4'd2, z: 1'b0};
    vecs[1] = '{a: 8'h9C,  b: 4'd7,  q: 8'hF2,  r: 4'hE, z: 1'b0};
    vecs[2] = '{a: 8'd100, b: 4'h9,  q: 8'hF2,  r: 4'd2, z: 1'b0};
    vecs[3] = '{a: 8'h9C,  b: 4'h9,  q: 8'd14,  r: 4'hE, z: 1'b0};
    vecs[4] = '{a: 8'h80,  b: 4'hF,  q: 8'h80,  r: 4'd0, z: 1'b0};
    vecs[5] = '{a: 8'h80,  b: 4'h8,  q: 8'd16,  r: 4'd0, z: 1'b0};
    vecs[6] = '{a: 8'd5,   b: 4'h8,  q: 8'd0,   r: 4'd5, z: 1'b0};
    vecs[7] = '{a: 8'd37,  b: 4'd0,  q: 8'hFF,  r: 4'd0, z: 1'b1};
    vecs[8] = '{a: 8'd9,   b: 4'd3,  q: 8'd3,   r: 4'd0, z: 1'b0};

    repeat (3) @(negedge clk);
    check("reset_quot", {24'd0, div_quot}, 32'd0);
    check("reset_rem", {28'd0, div_rem}, 32'd0);
    check("reset_valid", {31'd0, div_out_valid}, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors; each new op starts in the previous op's valid cycle.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i]);
      wait_done(M + 1);
    end
    repeat (2) @(negedge clk);

    // Enable during a busy op must be ignored.
    issue(vecs[0]);
    repeat (2) @(negedge clk);
    div_in_a   = 8'd1;
    div_in_b   = 4'd1;
    div_enable = 1'b1;
    @(negedge clk);
    div_enable = 1'b0;
    wait_done(M - 2);
    repeat (4) @(negedge clk);
    check("hold_quot", {24'd0, div_quot}, 32'd14);
    check("hold_rem", {28'd0, div_rem}, 32'd2);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of CALC.
    issue(vecs[1]);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_quot", {24'd0, div_quot}, 32'd0);
    check("arst_rem", {28'd0, div_rem}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_valid", {31'd0, div_out_valid}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_valid_after_abort", {31'd0, div_out_valid}, 32'd0);
    issue(vecs[3]);
    wait_done(M + 1);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
